// File: rtl/logic_reduce_unit.sv
// Streaming bitwise fold (AND/OR/XOR/NAND) of a valid/ready operand frame into one result.
// Optional out_parity port enabled by defining LOGIC_REDUCE_PARITY_EN.
module logic_reduce_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned COUNT_MAX = 16,
  parameter int unsigned CNT_W     = $clog2(COUNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
`ifdef LOGIC_REDUCE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  localparam logic [1:0] OpOr   = 2'b01;
  localparam logic [1:0] OpXor  = 2'b10;
  localparam logic [1:0] OpNand = 2'b11;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(COUNT_MAX);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_trunc_q, out_trunc_d;

  logic               beat;
  logic [1:0]         frame_op;
  logic [WIDTH-1:0]   folded;
  logic [WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               close;
  logic               close_trunc;

  assign in_ready = (state_q != StHold);
  assign beat     = in_valid && in_ready;
  // op is only honoured on the first beat; later beats use the latched op.
  assign frame_op = (state_q == StIdle) ? op : op_q;

  always_comb begin
    unique case (frame_op)
      OpOr:    folded = acc_q | in_data;
      OpXor:   folded = acc_q ^ in_data;
      default: folded = acc_q & in_data;
    endcase
  end

  assign acc_next = (state_q == StIdle) ? in_data : folded;
  assign cnt_next = (state_q == StIdle) ? CntOne : cnt_q + CntOne;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    close       = 1'b0;
    close_trunc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (beat) begin
          acc_d   = acc_next;
          cnt_d   = cnt_next;
          op_d    = op;
          state_d = StAccum;
          if (in_last) begin
            close   = 1'b1;
            state_d = StHold;
          end
        end
      end
      StAccum: begin
        if (beat) begin
          acc_d = acc_next;
          cnt_d = cnt_next;
          if (in_last) begin
            close   = 1'b1;
            state_d = StHold;
          end else if (cnt_next == CntMax) begin
            close       = 1'b1;
            close_trunc = 1'b1;
            state_d     = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Result registers only load on the closing beat, so they stay stable in HOLD and beyond.
  always_comb begin
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_trunc_d = out_trunc_q;
    if (close) begin
      out_data_d  = (frame_op == OpNand) ? ~acc_next : acc_next;
      out_count_d = cnt_next;
      out_trunc_d = close_trunc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_trunc = out_trunc_q;

`ifdef LOGIC_REDUCE_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (close) begin
      parity_q <= ^out_data_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Scoreboard bench for logic_reduce_unit (WIDTH=8, COUNT_MAX=4): directed frames, then random traffic.
module tb_logic_reduce_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned CM = 4;
  localparam int unsigned CW = $clog2(CM + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_trunc;
`ifdef LOGIC_REDUCE_PARITY_EN
  logic          out_parity;
`endif

  logic_reduce_unit #(.WIDTH(W), .COUNT_MAX(CM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_trunc (out_trunc)
`ifdef LOGIC_REDUCE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cnt;
    logic         trunc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] frame[$];
  logic [1:0]   frame_op;
  int           n_checks = 0;
  int           n_errors = 0;
  bit           rand_ready = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: fold the whole frame from its operand list once it closes.
  function automatic void model_beat(logic [W-1:0] d, logic last, logic [1:0] o);
    exp_t e;
    logic [W-1:0] r;
    if (frame.size() == 0) frame_op = o;
    frame.push_back(d);
    if (last || frame.size() == CM) begin
      r = frame[0];
      for (int i = 1; i < frame.size(); i++) begin
        case (frame_op)
          2'b01:   r = r | frame[i];
          2'b10:   r = r ^ frame[i];
          default: r = r & frame[i];
        endcase
      end
      e.data  = (frame_op == 2'b11) ? ~r : r;
      e.cnt   = frame.size();
      e.trunc = !last;
      sb.push_back(e);
      frame.delete();
      check("latency_out_valid", 32'(out_valid), 32'd1);
    end
  endfunction

  task automatic send_beat(logic [W-1:0] d, logic last, logic [1:0] o);
    bit accepted = 0;
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    op       = o;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!accepted) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_accept_timeout: got no accept expected accept within 200 cycles");
    end else begin
      model_beat(d, last, o);
    end
  endtask

  task automatic idle_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pop and compare whenever a result handshake is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got data 0x%0h expected no result", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_count", 32'(out_count), 32'(e.cnt));
          check("out_trunc", 32'(out_trunc), 32'(e.trunc));
`ifdef LOGIC_REDUCE_PARITY_EN
          check("out_parity", 32'(out_parity), 32'(^e.data));
`endif
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [W-1:0]  snap_data;
    logic [CW-1:0] snap_cnt;
    logic          snap_tr;
    int            len;
    int            guard;

    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_trunc", 32'(out_trunc), 32'd0);
`ifdef LOGIC_REDUCE_PARITY_EN
    check("rst_out_parity", 32'(out_parity), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed folds.
    send_beat(8'hF0, 0, 2'b00); send_beat(8'h3C, 0, 2'b00); send_beat(8'hFF, 1, 2'b00);
    send_beat(8'h01, 0, 2'b01); send_beat(8'h80, 1, 2'b01);
    send_beat(8'hAA, 0, 2'b10); send_beat(8'hFF, 1, 2'b10);
    send_beat(8'hF0, 1, 2'b11);
    // Truncation at COUNT_MAX, then the leftover operand forms its own frame.
    send_beat(8'h01, 0, 2'b01); send_beat(8'h02, 0, 2'b01); send_beat(8'h04, 0, 2'b01);
    send_beat(8'h08, 0, 2'b01); send_beat(8'h10, 1, 2'b01);
    // in_last exactly at COUNT_MAX is not a truncation.
    send_beat(8'hFF, 0, 2'b10); send_beat(8'h0F, 0, 2'b10); send_beat(8'h01, 0, 2'b10);
    send_beat(8'h80, 1, 2'b10);
    // op change mid-frame is ignored.
    send_beat(8'h0F, 0, 2'b00); send_beat(8'hF0, 1, 2'b01);

    // Backpressure: result held and input stalled.
    idle_cycles(2);
    out_ready = 1'b0;
    send_beat(8'hC3, 0, 2'b11); send_beat(8'hF0, 1, 2'b11);
    snap_data = out_data;
    snap_cnt  = out_count;
    snap_tr   = out_trunc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_data_stable", 32'(out_data), 32'(snap_data));
      check("bp_count_stable", 32'(out_count), 32'(snap_cnt));
      check("bp_trunc_stable", 32'(out_trunc), 32'(snap_tr));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle_cycles(1);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset mid-frame drops the partial frame.
    send_beat(8'h12, 0, 2'b01); send_beat(8'h34, 0, 2'b01);
    rst_n = 1'b0;
    frame.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_count", 32'(out_count), 32'd0);
    check("midrst_out_trunc", 32'(out_trunc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    send_beat(8'h55, 1, 2'b00);

    // Random traffic with random backpressure and op wobble.
    rand_ready = 1;
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        send_beat(W'($urandom), (b == len - 1), 2'($urandom));
        idle_cycles($urandom_range(0, 1));
      end
    end
    rand_ready = 0;
    out_ready  = 1'b1;

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      idle_cycles(1);
      guard++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("no_open_frame", 32'(frame.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
